// File: rtl/wb_regfile.sv
// wb_regfile: 32x32 register file with WB write-through bypass and retire counter.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        wwreg,
  input  logic        wm2reg,
  input  logic [31:0] mC,
  input  logic [31:0] mD,
  input  logic [4:0]  wrn,
  input  logic [31:0] winstr,
  input  logic [4:0]  rna,
  input  logic [4:0]  rnb,
  output logic [31:0] qa,
  output logic [31:0] qb,
  output logic [31:0] wdata,
  output logic [31:0] retire_cnt,
  output logic [31:0] last_instr
);
  logic [31:0] rf_q [32];
  logic [31:0] cnt_q, cnt_d, last_q, last_d;
  logic        we;
  always_comb begin
    wdata  = wm2reg ? mD : mC;
    we     = wwreg && wrn != 5'd0;
    qa     = rna == 5'd0 ? 32'd0 : (we && wrn == rna) ? wdata : rf_q[rna];
    qb     = rnb == 5'd0 ? 32'd0 : (we && wrn == rnb) ? wdata : rf_q[rnb];
    cnt_d  = winstr != 32'd0 ? cnt_q + 32'd1 : cnt_q;
    last_d = winstr != 32'd0 ? winstr : last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
      cnt_q  <= 32'd0;
      last_q <= 32'd0;
    end else begin
      if (we) rf_q[wrn] <= wdata;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end
  assign retire_cnt = cnt_q;
  assign last_instr = last_q;
endmodule
